multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM directly upstream of the datapath.
- Consumes the datapath's Option (instr[31:26]) and Function (instr[5:0]).
- Drives every datapath control input, plus new pc_we and ir_we enables. These enables let the datapath hold PC and the instruction register across a 3–5 cycle instruction.
- Also counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous reset, active-low: the block resets on a rising clk edge while reset is 0
Option  in  6  opcode from datapath, valid from DECODE onward
Function  in  6  funct field from datapath
Regdst  out  2  00 rt, 01 rd, 10 $31
Branch0  out  1  beq select
Branch1  out  1  j/jal select
Branch2  out  1  jr select
Branch3  out  1  bgez select
MemRead  out  1  dm read enable
MemtoReg  out  2  00 alu, 01 dm, 10 pc+4
ALUOp  out  3  000 add, 001 sub, 010 or, 011 passB
MemWrite  out  1  dm write enable
ALUSrc  out  1  0 Rdata2, 1 extnum
Regwrite  out  1  grf write enable
Sign  out  2  00 zero-ext, 01 sign-ext, 10 upper (lui)
pc_we  out  1  PC load enable (commit)
ir_we  out  1  instruction register load
state  out  3  current FSM state, for debug
retire  out  1  one-cycle pulse on commit
retire_cnt  out  CNT_W  retired instruction count
illegal  out  1  unknown-opcode flag

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset (reset==0 at an edge):
  - state<=FETCH, retire_cnt<=0, latched op/funct<=0, illegal<=0.
  - Reset mid-instruction aborts the instruction: no pc_we, Regwrite or MemWrite is issued.
- Outputs are Moore: decoded from state plus op/funct latched in DECODE. All outputs not listed for a state are 0.
- FETCH: ir_we=1. Next state DECODE.
- DECODE: latch Option/Function. Next state EXEC.
- Supported instructions: R-type (op 000000) with funct addu 100001, subu 100011, jr 001000; ori 001101; lui 001111; lw 100011; sw 101011; beq 000100; bgez 000001; j 000010; jal 000011.
- EXEC per class:
  - addu/subu: ALUOp add/sub, ALUSrc=0. Next WB.
  - ori: ALUOp or, ALUSrc=1, Sign=00. Next WB.
  - lui: ALUOp passB, ALUSrc=1, Sign=10. Next WB.
  - lw/sw: ALUOp add, ALUSrc=1, Sign=01. Next MEM.
  - beq: ALUOp sub, Sign=01, Branch0=1, pc_we=1, retire. Next FETCH.
  - bgez: Sign=01, Branch3=1, pc_we=1, retire. Next FETCH.
  - j: Branch1=1, pc_we=1, retire. Next FETCH.
  - jal: Branch1=1, Regdst=10, MemtoReg=10, Regwrite=1, pc_we=1, retire. Next FETCH.
  - jr: Branch2=1, pc_we=1, retire. Next FETCH.
- MEM:
  - lw: MemRead=1, with EXEC's ALU controls held. Next WB.
  - sw: MemWrite=1, with EXEC controls held, pc_we=1, retire. Next FETCH.
- WB:
  - R-type: Regdst=01, MemtoReg=00, EXEC ALU controls held.
  - ori/lui: Regdst=00, MemtoReg=00, EXEC ALU controls held.
  - lw: Regdst=00, MemtoReg=01, MemRead=1, EXEC ALU controls held.
  - All: Regwrite=1, pc_we=1, retire. Next FETCH.
- Latency: branch/jump 3 cycles; ALU and sw 4 cycles; lw 5 cycles.
- retire_cnt increments by 1 on every retire and wraps from all-ones to 0.
- Unknown opcode, or unknown funct under op 000000:
  - illegal pulses high in EXEC.
  - Treated as nop: pc_we=1, retire, no writes. Next FETCH.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode/funct in EXEC transitions to HALT, with no pc_we and no retire.
  - HALT outputs are all 0 except illegal=1 (sticky).
  - HALT is left only by reset.
- Undefined: nop behaviour as above; HALT is unreachable.

Decomposition:
- Shared package (mips_ctrl_pkg) holds:
  - state encodings
  - opcode/funct constants
  - ALUOp/Regdst/MemtoReg/Sign encodings
- One sub-module, ctrl_decode: combinational, latched op/funct -> instruction-class one-hot. The FSM module owns state, latches and the counter.

Test Plan:
- Reset held low 2 cycles, then released -> state=0, ir_we=1, retire_cnt=0, all write enables 0.
- addu (Option=0, Function=6'h21) -> states 0,1,2,4; in WB Regdst=01, Regwrite=1, pc_we=1; retire_cnt 0->1.
- lw (Option=6'h23) -> states 0,1,2,3,4; MEM MemRead=1; WB MemtoReg=01, Regwrite=1; exactly one pc_we in 5 cycles.
- beq then jal back-to-back -> each commits in 3 cycles; jal EXEC Regdst=10, MemtoReg=10, Regwrite=1; retire_cnt +2.
- Reset driven low during MEM of sw -> next state FETCH, MemWrite never asserted, retire_cnt unchanged.
- Option=6'h3F:
  - Macro undefined -> illegal pulse 1 cycle, pc_we=1, back to FETCH.
  - Macro defined -> state=5, illegal stays 1, pc_we 0 until reset.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcode/funct
// constants, datapath select encodings and instruction-class indices.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BGEZ  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_PASSB = 3'b011;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_DM  = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    localparam logic [1:0] SG_ZERO  = 2'b00;
    localparam logic [1:0] SG_SIGN  = 2'b01;
    localparam logic [1:0] SG_UPPER = 2'b10;

    // Bit positions of the one-hot instruction class vector
    localparam int C_ADDU = 0;
    localparam int C_SUBU = 1;
    localparam int C_JR   = 2;
    localparam int C_ORI  = 3;
    localparam int C_LUI  = 4;
    localparam int C_LW   = 5;
    localparam int C_SW   = 6;
    localparam int C_BEQ  = 7;
    localparam int C_BGEZ = 8;
    localparam int C_J    = 9;
    localparam int C_JAL  = 10;
    localparam int C_ILL  = 11;
    localparam int NCLS   = 12;

    typedef logic [NCLS-1:0] cls_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle FSM (master) and the datapath (slave).
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
    logic [5:0]       Option;
    logic [5:0]       Function;
    logic [1:0]       Regdst;
    logic             Branch0;
    logic             Branch1;
    logic             Branch2;
    logic             Branch3;
    logic             MemRead;
    logic [1:0]       MemtoReg;
    logic [2:0]       ALUOp;
    logic             MemWrite;
    logic             ALUSrc;
    logic             Regwrite;
    logic [1:0]       Sign;
    logic             pc_we;
    logic             ir_we;
    logic [2:0]       state;
    logic             retire;
    logic [CNT_W-1:0] retire_cnt;
    logic             illegal;

    modport master (
        input  Option, Function,
        output Regdst, Branch0, Branch1, Branch2, Branch3, MemRead, MemtoReg,
               ALUOp, MemWrite, ALUSrc, Regwrite, Sign, pc_we, ir_we, state,
               retire, retire_cnt, illegal
    );

    modport slave (
        output Option, Function,
        input  Regdst, Branch0, Branch1, Branch2, Branch3, MemRead, MemtoReg,
               ALUOp, MemWrite, ALUSrc, Regwrite, Sign, pc_we, ir_we, state,
               retire, retire_cnt, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_decode: latched opcode/funct -> one-hot instruction class; anything
// unrecognised lands in C_ILL.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output cls_t       cls
);
    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls[C_ADDU] = 1'b1;
                    FN_SUBU: cls[C_SUBU] = 1'b1;
                    FN_JR:   cls[C_JR]   = 1'b1;
                    default: cls[C_ILL]  = 1'b1;
                endcase
            end
            OP_ORI:  cls[C_ORI]  = 1'b1;
            OP_LUI:  cls[C_LUI]  = 1'b1;
            OP_LW:   cls[C_LW]   = 1'b1;
            OP_SW:   cls[C_SW]   = 1'b1;
            OP_BEQ:  cls[C_BEQ]  = 1'b1;
            OP_BGEZ: cls[C_BGEZ] = 1'b1;
            OP_J:    cls[C_J]    = 1'b1;
            OP_JAL:  cls[C_JAL]  = 1'b1;
            default: cls[C_ILL]  = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with retired-instruction counter.
// MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: illegal instructions park the FSM in HALT.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_ctrl_if.master   bus
);
    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d, fn_q, fn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cls_t             cls;
    logic             commit, regwr, memwr;
    logic [2:0]       alu_op;
    logic             alu_src;
    logic [1:0]       alu_sign;

    ctrl_decode u_decode (.op(op_q), .funct(fn_q), .cls(cls));

    // ALU controls chosen in EXEC and held through MEM/WB
    always_comb begin
        alu_op   = ALU_ADD;
        alu_src  = 1'b0;
        alu_sign = SG_ZERO;
        if (cls[C_SUBU]) alu_op = ALU_SUB;
        if (cls[C_ORI]) begin
            alu_op  = ALU_OR;
            alu_src = 1'b1;
        end
        if (cls[C_LUI]) begin
            alu_op   = ALU_PASSB;
            alu_src  = 1'b1;
            alu_sign = SG_UPPER;
        end
        if (cls[C_LW] || cls[C_SW]) begin
            alu_src  = 1'b1;
            alu_sign = SG_SIGN;
        end
        if (cls[C_BEQ]) begin
            alu_op   = ALU_SUB;
            alu_sign = SG_SIGN;
        end
        if (cls[C_BGEZ]) alu_sign = SG_SIGN;
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        fn_d         = fn_q;
        commit       = 1'b0;
        regwr        = 1'b0;
        memwr        = 1'b0;
        bus.Regdst   = RD_RT;
        bus.Branch0  = 1'b0;
        bus.Branch1  = 1'b0;
        bus.Branch2  = 1'b0;
        bus.Branch3  = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemtoReg = M2R_ALU;
        bus.ALUOp    = ALU_ADD;
        bus.ALUSrc   = 1'b0;
        bus.Sign     = SG_ZERO;
        bus.ir_we    = 1'b0;
        bus.illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.ir_we = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                op_d    = bus.Option;
                fn_d    = bus.Function;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                bus.ALUOp  = alu_op;
                bus.ALUSrc = alu_src;
                bus.Sign   = alu_sign;
                bus.Branch0 = cls[C_BEQ];
                bus.Branch1 = cls[C_J] | cls[C_JAL];
                bus.Branch2 = cls[C_JR];
                bus.Branch3 = cls[C_BGEZ];
                if (cls[C_JAL]) begin
                    bus.Regdst   = RD_RA;
                    bus.MemtoReg = M2R_PC4;
                    regwr        = 1'b1;
                end
                if (cls[C_ADDU] || cls[C_SUBU] || cls[C_ORI] || cls[C_LUI]) begin
                    state_d = S_WB;
                end else if (cls[C_LW] || cls[C_SW]) begin
                    state_d = S_MEM;
                end else if (cls[C_ILL]) begin
                    bus.illegal = 1'b1;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    commit  = 1'b1;
                    state_d = S_FETCH;
`endif
                end else begin
                    commit  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                bus.ALUOp  = alu_op;
                bus.ALUSrc = alu_src;
                bus.Sign   = alu_sign;
                if (cls[C_LW]) begin
                    bus.MemRead = 1'b1;
                    state_d     = S_WB;
                end else begin
                    memwr   = 1'b1;
                    commit  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                bus.ALUOp  = alu_op;
                bus.ALUSrc = alu_src;
                bus.Sign   = alu_sign;
                bus.Regdst = (cls[C_ADDU] || cls[C_SUBU]) ? RD_RD : RD_RT;
                if (cls[C_LW]) begin
                    bus.MemtoReg = M2R_DM;
                    bus.MemRead  = 1'b1;
                end
                regwr   = 1'b1;
                commit  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: bus.illegal = 1'b1;
            default: state_d = S_FETCH;
        endcase
        // A cycle spent in reset must not commit or write: this aborts the instruction
        bus.pc_we    = commit & reset;
        bus.retire   = commit & reset;
        bus.Regwrite = regwr & reset;
        bus.MemWrite = memwr & reset;
        cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, bus.retire};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each instruction pushes its per-cycle
// expected outputs; a negedge monitor pops and compares.
module tb_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    localparam int CW = 4;
    localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5,
                   K_BEQ = 6, K_BGEZ = 7, K_J = 8, K_JAL = 9, K_JR = 10, K_ILL = 11;

    typedef struct packed {
        logic [1:0] regdst;
        logic       b0, b1, b2, b3, memrd;
        logic [1:0] m2r;
        logic [2:0] aluop;
        logic       memwr, alusrc, regwr;
        logic [1:0] sign;
        logic       pcwe, irwe, ret, ill;
    } ctl_t;

    typedef struct {
        string       nm;
        logic [2:0]  st;
        ctl_t        c;
        logic [CW-1:0] cnt;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CW)) bus ();
    multicycle_ctrl #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    rec_t          q[$];
    int            checks = 0;
    int            passes = 0;
    logic [CW-1:0] ecnt = '0;

    function automatic ctl_t sample();
        return {bus.Regdst, bus.Branch0, bus.Branch1, bus.Branch2, bus.Branch3,
                bus.MemRead, bus.MemtoReg, bus.ALUOp, bus.MemWrite, bus.ALUSrc,
                bus.Regwrite, bus.Sign, bus.pc_we, bus.ir_we, bus.retire, bus.illegal};
    endfunction

    always @(negedge clk) begin
        rec_t r;
        ctl_t a;
        if (q.size() > 0) begin
            r = q.pop_front();
            a = sample();
            checks++;
            if (bus.state === r.st && a === r.c && bus.retire_cnt === r.cnt)
                passes++;
            else
                $display("FAIL %s: got state=%0d ctl=%h cnt=%0d, want state=%0d ctl=%h cnt=%0d",
                         r.nm, bus.state, a, bus.retire_cnt, r.st, r.c, r.cnt);
        end
    end

    task automatic push(input string nm, input logic [2:0] st, input ctl_t c);
        rec_t r;
        r.nm = nm; r.st = st; r.c = c; r.cnt = ecnt;
        q.push_back(r);
    endtask

    // Called at posedge+1 with the DUT in FETCH; returns the same way.
    task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn, input int k);
        ctl_t e;
        int   n;
        bus.Option   = op;
        bus.Function = fn;
        e = '0; e.irwe = 1'b1;
        push({nm, ".fetch"}, 3'd0, e);
        e = '0;
        push({nm, ".decode"}, 3'd1, e);
        e = '0;
        n = 3;
        case (k)
            K_ADDU, K_SUBU, K_ORI, K_LUI: begin
                if (k == K_SUBU) e.aluop = 3'b001;
                if (k == K_ORI) begin e.aluop = 3'b010; e.alusrc = 1'b1; end
                if (k == K_LUI) begin e.aluop = 3'b011; e.alusrc = 1'b1; e.sign = 2'b10; end
                push({nm, ".exec"}, 3'd2, e);
                e.regdst = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
                e.regwr = 1'b1; e.pcwe = 1'b1; e.ret = 1'b1;
                push({nm, ".wb"}, 3'd4, e);
                n = 4;
            end
            K_LW: begin
                e.alusrc = 1'b1; e.sign = 2'b01;
                push({nm, ".exec"}, 3'd2, e);
                e.memrd = 1'b1;
                push({nm, ".mem"}, 3'd3, e);
                e.m2r = 2'b01; e.regwr = 1'b1; e.pcwe = 1'b1; e.ret = 1'b1;
                push({nm, ".wb"}, 3'd4, e);
                n = 5;
            end
            K_SW: begin
                e.alusrc = 1'b1; e.sign = 2'b01;
                push({nm, ".exec"}, 3'd2, e);
                e.memwr = 1'b1; e.pcwe = 1'b1; e.ret = 1'b1;
                push({nm, ".mem"}, 3'd3, e);
                n = 4;
            end
            K_ILL: begin
                e.ill = 1'b1;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                push({nm, ".exec"}, 3'd2, e);
                for (int i = 0; i < 3; i++) push({nm, ".halt"}, 3'd5, e);
                n = 6;
`else
                e.pcwe = 1'b1; e.ret = 1'b1;
                push({nm, ".exec"}, 3'd2, e);
`endif
            end
            default: begin
                if (k == K_BEQ)  begin e.aluop = 3'b001; e.sign = 2'b01; e.b0 = 1'b1; end
                if (k == K_BGEZ) begin e.sign = 2'b01; e.b3 = 1'b1; end
                if (k == K_J)    e.b1 = 1'b1;
                if (k == K_JR)   e.b2 = 1'b1;
                if (k == K_JAL)  begin e.b1 = 1'b1; e.regdst = 2'b10; e.m2r = 2'b10; e.regwr = 1'b1; end
                e.pcwe = 1'b1; e.ret = 1'b1;
                push({nm, ".exec"}, 3'd2, e);
            end
        endcase
        if (e.ret) ecnt = ecnt + 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        ctl_t e;
        bus.Option   = 6'h00;
        bus.Function = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        e = '0; e.irwe = 1'b1;
        push("reset", 3'd0, e);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run("addu",  OP_RTYPE, FN_ADDU, K_ADDU);
        run("lw",    OP_LW,    6'h00,   K_LW);
        run("beq",   OP_BEQ,   6'h00,   K_BEQ);
        run("jal",   OP_JAL,   6'h00,   K_JAL);
        run("subu",  OP_RTYPE, FN_SUBU, K_SUBU);
        run("ori",   OP_ORI,   6'h15,   K_ORI);
        run("lui",   OP_LUI,   6'h00,   K_LUI);
        run("sw",    OP_SW,    6'h00,   K_SW);
        run("bgez",  OP_BGEZ,  6'h00,   K_BGEZ);
        run("j",     OP_J,     6'h00,   K_J);
        run("jr",    OP_RTYPE, FN_JR,   K_JR);
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        run("badfn", OP_RTYPE, 6'h3F,   K_ILL);
`endif
        // Enough retires to carry the 4-bit counter through all-ones to zero
        for (int i = 0; i < 6; i++) run("wrap", OP_RTYPE, FN_ADDU, K_ADDU);

        // sw with reset asserted during MEM: no MemWrite, no retire
        bus.Option = OP_SW;
        e = '0; e.irwe = 1'b1;
        push("swrst.fetch", 3'd0, e);
        e = '0;
        push("swrst.decode", 3'd1, e);
        e.alusrc = 1'b1; e.sign = 2'b01;
        push("swrst.exec", 3'd2, e);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        push("swrst.mem", 3'd3, e);
        @(posedge clk);
        #1;
        reset = 1'b1;
        ecnt = '0;
        run("post_rst", OP_RTYPE, FN_ADDU, K_ADDU);

        run("badop", 6'h3F, 6'h00, K_ILL);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        reset = 1'b0;
        e = '0; e.ill = 1'b1;
        push("halt.rst", 3'd5, e);
        @(posedge clk);
        #1;
        reset = 1'b1;
        ecnt = '0;
        run("post_trap", OP_RTYPE, FN_ADDU, K_ADDU);
`endif

        repeat (2) @(posedge clk);
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending records, want 0", q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
